intr_ctrl: RTL and testbench

Interrupt controller that feeds the pipeline control unit's `intr` / `imip[7:0]` inputs and consumes its `inta` acknowledge. It synchronises 8 external interrupt lines, latches them as pending, and applies a mask and per-source edge/level mode. It presents one prioritised request at a time and tracks the in-service source until the handler executes ERET. A small config port lets software program mask and mode, read pending and in-service state, and clear pending bits.

---
 rtl/intr_ctrl_pkg.sv | 27 ++
 rtl/irq_sync_edge.sv | 31 +++
 rtl/intr_ctrl.sv | 129 ++++++++++++
 tb/tb_intr_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, config
// register map, FSM states and the one-hot to binary encoder.
package intr_ctrl_pkg;

  localparam int NSRC_DEF = 8;

  localparam logic [1:0] ADDR_IMASK  = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_INSERV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  function automatic logic [2:0] onehot_to_bin(input logic [NSRC_DEF-1:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < NSRC_DEF; i++) begin
      if (oh[i]) b = b | i[2:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser for an asynchronous interrupt input, followed by a
// one-flop history that yields a single-cycle rise indication.
module irq_sync_edge
  import intr_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises NSRC lines, latches them as pending,
// and presents one lowest-index-wins request to the control unit at a time.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_in,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [NSRC-1:0] cfg_wdata,
  output logic [NSRC-1:0] cfg_rdata,
  output logic            intr,
  output logic [NSRC-1:0] imip,
  input  logic            inta,
  input  logic            eret,
  output logic [2:0]      irq_id,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Request handshake: intr/imip are held stable from entry into ASSERT
  // until either inta is seen (accept, move to SERVICE) or the presented
  // source loses eligibility (retract). There is no timeout on inta.

  logic [NSRC-1:0] s_vec, rise_vec;
  logic [NSRC-1:0] imask_q, edge_q, pend_q, inserv_q, cur_q;
  logic [NSRC-1:0] pend_d, inserv_d, cur_d;
  logic [NSRC-1:0] eligible, sel, w1c, clr;
  logic [2:0]      irq_id_q, irq_id_d;
  logic            ack;
  state_e          state_q, state_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_in (irq_in[g]),
      .s      (s_vec[g]),
      .rise   (rise_vec[g])
    );
  end

  assign eligible = pend_q & imask_q;
  // Isolate the lowest set bit: x & -x.
  assign sel      = eligible & (~eligible + {{(NSRC-1){1'b0}}, 1'b1});

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    inserv_d = inserv_q;
    irq_id_d = irq_id_q;
    ack      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          cur_d   = sel;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (inta) begin
          ack      = 1'b1;
          inserv_d = inserv_q | cur_q;
          irq_id_d = onehot_to_bin(cur_q);
          state_d  = ST_SERVICE;
        end else if ((cur_q & eligible) == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          inserv_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge-mode bits latch rises and clear on W1C or acknowledge; level-mode
  // bits simply follow the synchronised line.
  always_comb begin
    w1c    = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata : '0;
    clr    = w1c | (ack ? cur_q : '0);
    pend_d = (edge_q & (pend_q | rise_vec) & ~clr) | (~edge_q & s_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      inserv_q <= '0;
      irq_id_q <= '0;
      pend_q   <= '0;
      imask_q  <= '0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      inserv_q <= inserv_d;
      irq_id_q <= irq_id_d;
      pend_q   <= pend_d;
      if (cfg_we && cfg_addr == ADDR_IMASK) imask_q <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_EDGE)  edge_q  <= cfg_wdata;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_IMASK:  cfg_rdata = imask_q;
      ADDR_EDGE:   cfg_rdata = edge_q;
      ADDR_PEND:   cfg_rdata = pend_q;
      ADDR_INSERV: cfg_rdata = inserv_q;
      default:     cfg_rdata = '0;
    endcase
  end

  assign intr      = (state_q == ST_ASSERT);
  assign imip      = intr ? cur_q : '0;
  assign busy      = (state_q == ST_SERVICE);
  assign irq_id    = irq_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: register table, directed corner-case
// sequences, and randomized traffic against a behavioural model.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  localparam int NSRC = 8;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSRC-1:0] irq_in;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [NSRC-1:0] cfg_wdata;
  logic [NSRC-1:0] cfg_rdata;
  logic            intr;
  logic [NSRC-1:0] imip;
  logic            inta;
  logic            eret;
  logic [2:0]      irq_id;
  logic            busy;
  logic [1:0]      dbg_state;

  intr_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .intr      (intr),
    .imip      (imip),
    .inta      (inta),
    .eret      (eret),
    .irq_id    (irq_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- checkers ----------------
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk8(name, cfg_rdata, exp);
  endtask

  task automatic wait_intr(input string name, output int n);
    n = 0;
    while (!intr && n < 30) begin
      tick();
      n++;
    end
    if (!intr) chkb({name, "_timeout"}, intr, 1'b1);
  endtask

  task automatic pulse_irq(input int idx);
    irq_in[idx] = 1'b1;
    tick();
    irq_in[idx] = 1'b0;
  endtask

  task automatic ack();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr;
    logic [7:0] exp;
  } cfg_vec_t;

  cfg_vec_t vecs[6];

  // ---------------- behavioural model + scoreboard ----------------
  logic [7:0] m_mask, m_edge, m_pend;
  logic [7:0] m_hist[$];     // irq_in samples, newest first
  int         m_phase;       // 0 waiting, 1 presenting, 2 in service
  int         m_cur;
  bit         m_just_acked;
  logic [2:0] exp_q[$];

  task automatic model_init(input logic [7:0] mask, input logic [7:0] edg);
    m_mask = mask; m_edge = edg; m_pend = '0;
    m_phase = 0; m_cur = 0; m_just_acked = 0;
    m_hist = {};
    for (int i = 0; i <= SS; i++) m_hist.push_back(8'h00);
    exp_q = {};
  endtask

  task automatic model_step(input logic [7:0] irq_v, input logic inta_v, input logic eret_v);
    logic [7:0] s, sd, clr, np;
    bit found;
    s = m_hist[SS-1];
    sd = m_hist[SS];
    clr = '0;
    found = 0;
    m_just_acked = 0;
    case (m_phase)
      0: for (int i = 0; i < NSRC; i++) begin
           if (!found && m_pend[i] && m_mask[i]) begin
             found = 1; m_cur = i; m_phase = 1;
           end
         end
      1: if (inta_v) begin
           clr[m_cur] = 1'b1; m_phase = 2; m_just_acked = 1;
           exp_q.push_back(3'(m_cur));
         end else if (!(m_pend[m_cur] && m_mask[m_cur])) begin
           m_phase = 0;
         end
      default: if (eret_v) m_phase = 0;
    endcase
    for (int i = 0; i < NSRC; i++) begin
      if (m_edge[i]) np[i] = (m_pend[i] | (s[i] & ~sd[i])) & ~clr[i];
      else           np[i] = s[i];
    end
    m_pend = np;
    m_hist.push_front(irq_v);
    void'(m_hist.pop_back());
  endtask

  // ---------------- main test ----------------
  initial begin
    int n;
    logic [7:0] rmask, redge;
    logic [2:0] eid;

    rst_n = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    inta = 1'b0; eret = 1'b0;
    tick(); tick();
    chkb("rst_intr", intr, 1'b0);
    chk8("rst_imip", imip, 8'h00);
    chkb("rst_busy", busy, 1'b0);
    chk8("rst_irq_id", {5'b0, irq_id}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_reg("rst_imask", ADDR_IMASK, 8'h00);
    chk_reg("rst_edge", ADDR_EDGE, 8'h00);
    chk_reg("rst_pend", ADDR_PEND, 8'h00);
    chk_reg("rst_inserv", ADDR_INSERV, 8'h00);

    vecs[0] = '{ADDR_IMASK,  8'hA5, ADDR_IMASK,  8'hA5};
    vecs[1] = '{ADDR_EDGE,   8'h3C, ADDR_EDGE,   8'h3C};
    vecs[2] = '{ADDR_INSERV, 8'hFF, ADDR_INSERV, 8'h00};
    vecs[3] = '{ADDR_PEND,   8'hFF, ADDR_PEND,   8'h00};
    vecs[4] = '{ADDR_IMASK,  8'h5A, ADDR_EDGE,   8'h3C};
    vecs[5] = '{ADDR_EDGE,   8'hC3, ADDR_IMASK,  8'h5A};
    for (int i = 0; i < 6; i++) begin
      cfg_write(vecs[i].waddr, vecs[i].wdata);
      chk_reg($sformatf("cfg_vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end
    chkb("cfg_no_intr", intr, 1'b0);

    // 1: edge source 0, latency, ack clears pending, eret clears in-service
    cfg_write(ADDR_IMASK, 8'hFF);
    cfg_write(ADDR_EDGE, 8'h01);
    pulse_irq(0);
    wait_intr("t1", n);
    chk8("t1_latency", 8'(n + 1), 8'(SS + 2));
    chk8("t1_imip", imip, 8'h01);
    ack();
    chkb("t1_intr_after_ack", intr, 1'b0);
    chkb("t1_busy", busy, 1'b1);
    chk8("t1_irq_id", {5'b0, irq_id}, 8'h00);
    chk_reg("t1_pend", ADDR_PEND, 8'h00);
    chk_reg("t1_inserv", ADDR_INSERV, 8'h01);
    do_eret();
    chkb("t1_busy_after_eret", busy, 1'b0);
    chk_reg("t1_inserv_after_eret", ADDR_INSERV, 8'h00);

    // 2: level sources 5 and 2; 2 re-presents while held high
    cfg_write(ADDR_EDGE, 8'h00);
    irq_in = 8'h24;
    wait_intr("t2a", n);
    chk8("t2_imip_a", imip, 8'h04);
    ack();
    chk8("t2_irq_id_a", {5'b0, irq_id}, 8'h02);
    do_eret();
    wait_intr("t2b", n);
    chk8("t2_imip_b", imip, 8'h04);
    irq_in = 8'h20;
    ack();
    repeat (5) tick();
    do_eret();
    wait_intr("t2c", n);
    chk8("t2_imip_c", imip, 8'h20);
    ack();
    chk8("t2_irq_id_c", {5'b0, irq_id}, 8'h05);
    irq_in = 8'h00;
    repeat (5) tick();
    do_eret();
    repeat (3) tick();
    chkb("t2_idle", intr, 1'b0);

    // 3: presented source is held while a higher-priority one arrives
    cfg_write(ADDR_EDGE, 8'hFF);
    pulse_irq(3);
    wait_intr("t3a", n);
    chk8("t3_imip_a", imip, 8'h08);
    pulse_irq(1);
    repeat (6) tick();
    chk8("t3_imip_held", imip, 8'h08);
    chk_reg("t3_pend", ADDR_PEND, 8'h0A);
    ack();
    chk8("t3_irq_id_a", {5'b0, irq_id}, 8'h03);
    do_eret();
    wait_intr("t3b", n);
    chk8("t3_imip_b", imip, 8'h02);
    ack();
    chk8("t3_irq_id_b", {5'b0, irq_id}, 8'h01);
    do_eret();
    tick();
    chkb("t3_idle", intr, 1'b0);

    // 4: masking the presented source retracts; pending survives
    pulse_irq(4);
    wait_intr("t4a", n);
    chk8("t4_imip_a", imip, 8'h10);
    cfg_write(ADDR_IMASK, 8'hEF);
    tick();
    chkb("t4_retract", intr, 1'b0);
    chk8("t4_state", {6'b0, dbg_state}, 8'(ST_IDLE));
    chk_reg("t4_pend", ADDR_PEND, 8'h10);
    repeat (3) tick();
    chkb("t4_stays_idle", intr, 1'b0);
    cfg_write(ADDR_IMASK, 8'hFF);
    wait_intr("t4b", n);
    chk8("t4_imip_b", imip, 8'h10);
    ack();
    do_eret();

    // 5: same-cycle inta and W1C; eret in IDLE ignored
    pulse_irq(0);
    wait_intr("t5", n);
    chk8("t5_imip", imip, 8'h01);
    inta = 1'b1; cfg_we = 1'b1; cfg_addr = ADDR_PEND; cfg_wdata = 8'h01;
    tick();
    inta = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;
    chkb("t5_busy", busy, 1'b1);
    chk8("t5_irq_id", {5'b0, irq_id}, 8'h00);
    chkb("t5_intr", intr, 1'b0);
    do_eret();
    tick();
    do_eret();
    chk8("t5_state", {6'b0, dbg_state}, 8'(ST_IDLE));
    chkb("t5_busy_idle", busy, 1'b0);
    chkb("t5_intr_idle", intr, 1'b0);

    // 6: asynchronous reset during SERVICE
    pulse_irq(2);
    pulse_irq(6);
    wait_intr("t6", n);
    chk8("t6_imip", imip, 8'h04);
    ack();
    chkb("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chkb("t6_rst_intr", intr, 1'b0);
    chk8("t6_rst_imip", imip, 8'h00);
    chkb("t6_rst_busy", busy, 1'b0);
    chk_reg("t6_rst_pend", ADDR_PEND, 8'h00);
    chk_reg("t6_rst_imask", ADDR_IMASK, 8'h00);
    tick();
    rst_n = 1'b1;
    irq_in = 8'h80;
    repeat (6) tick();
    chkb("t6_masked", intr, 1'b0);
    chk_reg("t6_level_pend", ADDR_PEND, 8'h80);
    cfg_write(ADDR_IMASK, 8'hFF);
    wait_intr("t6b", n);
    chk8("t6_imip_b", imip, 8'h80);
    irq_in = 8'h00;
    repeat (6) tick();
    chkb("t6_level_retract", intr, 1'b0);

    // Randomized traffic against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rmask = 8'($urandom_range(0, 255)) | 8'h81;
      redge = 8'($urandom_range(0, 255));
      cfg_write(ADDR_IMASK, rmask);
      cfg_write(ADDR_EDGE, redge);
      model_init(rmask, redge);
      cfg_addr = ADDR_PEND;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 9) < 3) irq_in = 8'($urandom_range(0, 255));
        inta = (m_phase == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
        eret = (m_phase == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
        @(posedge clk);
        model_step(irq_in, inta, eret);
        #1;
        chkb($sformatf("rnd%0d_intr", r), intr, m_phase == 1);
        chk8($sformatf("rnd%0d_imip", r), imip, (m_phase == 1) ? 8'(1 << m_cur) : 8'h00);
        chkb($sformatf("rnd%0d_busy", r), busy, m_phase == 2);
        chk8($sformatf("rnd%0d_pend", r), cfg_rdata, m_pend);
        if (m_just_acked && exp_q.size() > 0) begin
          eid = exp_q.pop_front();
          chk8($sformatf("rnd%0d_irq_id", r), {5'b0, irq_id}, {5'b0, eid});
        end
      end
      inta = 1'b0; eret = 1'b0; irq_in = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
